// File: rtl/pong_score_fsm_if.sv
// Game-control bus between the pong event/button logic and the score FSM.
// master drives events and buttons; slave returns score, balls, freeze flag and state.
interface pong_score_fsm_if;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [1:0] ball;
    logic       gra_still;
    logic [1:0] state;

    modport master (
        output refr_tick, btn, hit, miss,
        input  dig0, dig1, ball, gra_still, state
    );

    modport slave (
        input  refr_tick, btn, hit, miss,
        output dig0, dig1, ball, gra_still, state
    );
endinterface

// File: rtl/pong_score_fsm.sv
// Pong game control: BCD score, ball count, inter-ball pause timer and graphics freeze.
// All outputs registered, 1-cycle latency; no backpressure, event pulses are consumed as they arrive.
module pong_score_fsm #(
    parameter int BALLS        = 3,
    parameter int PAUSE_FRAMES = 120,
    parameter int TIMER_W      = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pong_score_fsm_if.slave bus_io
);
    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_e;

    localparam logic [1:0]         BALLS_L = 2'(BALLS);
    localparam logic [TIMER_W-1:0] PAUSE_L = TIMER_W'(PAUSE_FRAMES);

    state_e             state_q, state_d;
    logic [3:0]         dig0_q, dig0_d;
    logic [3:0]         dig1_q, dig1_d;
    logic [1:0]         ball_q, ball_d;
    logic               still_q;
    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        state_d = state_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        ball_d  = ball_q;
        timer_d = (bus_io.refr_tick && timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;

        case (state_q)
            NEWGAME: begin
                if (bus_io.btn != 2'b00) begin
                    ball_d  = BALLS_L - 2'd1;
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus_io.hit) begin
                    if (dig0_q == 4'd9) begin
                        dig0_d = 4'd0;
                        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
                    end else begin
                        dig0_d = dig0_q + 4'd1;
                    end
                end
                // A miss reloads the pause even if a tick would decrement this cycle.
                if (bus_io.miss) begin
                    timer_d = PAUSE_L;
                    if (ball_q == 2'd0) begin
                        state_d = OVER;
                    end else begin
                        ball_d  = ball_q - 2'd1;
                        state_d = NEWBALL;
                    end
                end
            end
            NEWBALL: begin
                if (timer_q == '0 && bus_io.btn != 2'b00) state_d = PLAY;
            end
            OVER: begin
                if (timer_q == '0) begin
                    state_d = NEWGAME;
                    ball_d  = BALLS_L;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= NEWGAME;
            dig0_q  <= 4'd0;
            dig1_q  <= 4'd0;
            ball_q  <= BALLS_L;
            still_q <= 1'b1;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            ball_q  <= ball_d;
            still_q <= (state_d != PLAY);
            timer_q <= timer_d;
        end
    end

    assign bus_io.state     = state_q;
    assign bus_io.dig0      = dig0_q;
    assign bus_io.dig1      = dig1_q;
    assign bus_io.ball      = ball_q;
    assign bus_io.gra_still = still_q;
endmodule

// File: tb/tb_pong_score_fsm.sv
// Bench for pong_score_fsm: directed scenarios plus random events against a game-level score model.
module tb_pong_score_fsm;
    localparam int BALLS = 3;
    localparam int PAUSE = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pong_score_fsm_if bus();

    pong_score_fsm #(.BALLS(BALLS), .PAUSE_FRAMES(PAUSE), .TIMER_W(7)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Model: state code, score as an integer 0..99, balls left, frames of pause left.
    int m_state, m_score, m_ball, m_timer;

    logic [12:0] dut_vec;
    assign dut_vec = {bus.state, bus.dig1, bus.dig0, bus.ball, bus.gra_still};

    function automatic logic [12:0] exp_vec();
        return {2'(m_state), 4'(m_score / 10), 4'(m_score % 10), 2'(m_ball), 1'(m_state != 1)};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_ball = BALLS; m_timer = 0;
    endfunction

    function automatic void model_step(input logic t, input logic [1:0] b, input logic h, input logic m);
        int ns = m_state;
        int nt = (t && m_timer > 0) ? m_timer - 1 : m_timer;
        if (m_state == 0 && b != 0) begin
            m_ball = BALLS - 1; m_score = 0; ns = 1;
        end else if (m_state == 1) begin
            if (h) m_score = (m_score + 1) % 100;
            if (m) begin
                nt = PAUSE;
                if (m_ball == 0) ns = 3;
                else begin m_ball = m_ball - 1; ns = 2; end
            end
        end else if (m_state == 2 && m_timer == 0 && b != 0) begin
            ns = 1;
        end else if (m_state == 3 && m_timer == 0) begin
            ns = 0; m_ball = BALLS;
        end
        m_state = ns;
        m_timer = nt;
    endfunction

    task automatic drive(input logic t, input logic [1:0] b, input logic h, input logic m);
        @(negedge clk);
        bus.refr_tick = t; bus.btn = b; bus.hit = h; bus.miss = m;
        @(posedge clk);
        model_step(t, b, h, m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (dut_vec !== 13'b00_0000_0000_11_1) begin
            bad++; $display("FAIL reset_hold: dut=%h exp=%h", dut_vec, 13'b00_0000_0000_11_1);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_release: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_start();
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        total++;
        if ({bus.state, bus.ball, bus.gra_still} !== 5'b01_10_0) begin
            bad++; $display("FAIL start: dut=%b exp=%b", {bus.state, bus.ball, bus.gra_still}, 5'b01_10_0);
        end
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL start_btn_held: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bcd();
        repeat (9) drive(1'b0, 2'b00, 1'b1, 1'b0);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h09) begin
            bad++; $display("FAIL bcd_9: dut=%h exp=09", {bus.dig1, bus.dig0});
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h10) begin
            bad++; $display("FAIL bcd_carry: dut=%h exp=10", {bus.dig1, bus.dig0});
        end
        repeat (90) drive(1'b0, 2'b00, 1'b1, 1'b0);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h00 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL bcd_wrap: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_miss_pause();
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        total++;
        if ({bus.state, bus.ball, bus.gra_still} !== 5'b10_01_1) begin
            bad++; $display("FAIL miss: dut=%b exp=%b", {bus.state, bus.ball, bus.gra_still}, 5'b10_01_1);
        end
        for (int i = 1; i <= PAUSE; i++) begin
            drive(1'b1, 2'b10, 1'b0, 1'b0);
            total++;
            if (bus.state !== 2'b10) begin
                bad++; $display("FAIL pause_tick%0d: state=%b exp=10", i, bus.state);
            end
        end
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        total++;
        if (bus.state !== 2'b01 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL pause_exit: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        repeat (4) drive(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        total++;
        if ({bus.state, bus.dig1, bus.dig0, bus.ball} !== {2'b10, 8'h05, 2'b00}) begin
            bad++; $display("FAIL hit_and_miss: dut=%h exp=%h",
                            {bus.state, bus.dig1, bus.dig0, bus.ball}, {2'b10, 8'h05, 2'b00});
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        total++;
        if ({bus.state, bus.dig1, bus.dig0} !== {2'b10, 8'h05}) begin
            bad++; $display("FAIL hit_in_newball: dut=%h exp=%h", {bus.state, bus.dig1, bus.dig0}, {2'b10, 8'h05});
        end
    endtask

    task automatic test_game_over();
        repeat (PAUSE) drive(1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        total++;
        if (bus.state !== 2'b01) begin
            bad++; $display("FAIL last_ball_play: state=%b exp=01", bus.state);
        end
        repeat (7) drive(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        total++;
        if ({bus.state, bus.ball, bus.gra_still} !== 5'b11_00_1) begin
            bad++; $display("FAIL over: dut=%b exp=%b", {bus.state, bus.ball, bus.gra_still}, 5'b11_00_1);
        end
        repeat (PAUSE) drive(1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        total++;
        if (dut_vec !== {2'b00, 8'h12, 2'b11, 1'b1}) begin
            bad++; $display("FAIL over_exit: dut=%h exp=%h", dut_vec, {2'b00, 8'h12, 2'b11, 1'b1});
        end
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        total++;
        if (dut_vec !== {2'b01, 8'h00, 2'b10, 1'b0}) begin
            bad++; $display("FAIL new_game_clear: dut=%h exp=%h", dut_vec, {2'b01, 8'h00, 2'b10, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        repeat (37) drive(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (60) drive(1'b1, 2'b00, 1'b0, 1'b0);
        total++;
        if ({bus.state, bus.dig1, bus.dig0} !== {2'b10, 8'h37}) begin
            bad++; $display("FAIL pre_reset: dut=%h exp=%h", {bus.state, bus.dig1, bus.dig0}, {2'b10, 8'h37});
        end
        @(negedge clk);
        bus.refr_tick = 1'b0; bus.btn = 2'b00; bus.hit = 1'b0; bus.miss = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_vec !== 13'b00_0000_0000_11_1) begin
            bad++; $display("FAIL reset_mid: dut=%h exp=%h", dut_vec, 13'b00_0000_0000_11_1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_mid_release: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic       t, h, m;
        logic [1:0] b;
        for (int n = 0; n < 8000; n++) begin
            t = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            h = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 39) == 0);
            drive(t, b, h, m);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random_cycle%0d: dut=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.refr_tick = 1'b0;
        bus.btn       = 2'b00;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        model_reset();
        test_reset();
        test_start();
        test_bcd();
        test_miss_pause();
        test_simultaneous();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pong_score_fsm.md
# pong_score_fsm

Game-control stage for the pong display path. It sits directly upstream of the text overlay and drives the two BCD score digits, the remaining-ball count and the graphics-freeze flag that the overlay and graphics stages consume. Its inputs are:
- per-event pulses from the ball/paddle logic;
- the player buttons;
- a once-per-frame refresh tick derived from the VGA sync counters.

## Interface
Parameters:
- BALLS, 3, balls issued per game; legal range 1..3.
- PAUSE_FRAMES, 120, refresh ticks of pause after a miss (2 s at 60 Hz); legal range 1..127.
- TIMER_W, 7, pause-timer width; must satisfy 2^TIMER_W > PAUSE_FRAMES.

Ports:
- clk  in  1  system clock; single clock domain, same clock as the VGA sync unit.
- reset  in  1  asynchronous, active-high.
- refr_tick  in  1  one-cycle pulse, once per video frame.
- btn  in  2  player buttons, already debounced and synchronous, level-sensitive.
- hit  in  1  one-cycle pulse: ball struck paddle.
- miss  in  1  one-cycle pulse: ball passed paddle.
- dig0  out  4  score units digit, BCD.
- dig1  out  4  score tens digit, BCD.
- ball  out  2  balls remaining after the one in play.
- gra_still  out  1  1 = graphics frozen (ball not moving).
- state  out  2  current game state encoding, for the text stage.

## Operation
- All outputs are registered.
- Reset values:
  - state = NEWGAME (00)
  - dig0 = dig1 = 0
  - ball = BALLS
  - gra_still = 1
  - internal timer = 0
- States:
  - NEWGAME (00): gra_still = 1. If btn != 0, then ball <= BALLS-1, dig0 <= dig1 <= 0, and the next state is PLAY. Otherwise the last score stays displayed.
  - PLAY (01): gra_still = 0.
    - hit: score increments.
    - miss with ball == 0: load the timer with PAUSE_FRAMES and go to OVER.
    - miss with ball != 0: ball <= ball-1, load the timer with PAUSE_FRAMES, and go to NEWBALL.
  - NEWBALL (10): gra_still = 1. When timer == 0 and btn != 0, go to PLAY.
  - OVER (11): gra_still = 1. When timer == 0, go to NEWGAME; ball <= BALLS on that transition. The score is retained.
- Pause timer:
  - Decrements by 1 on each cycle where refr_tick = 1 and timer != 0.
  - Holds at 0.
  - A load takes priority over a decrement in the same cycle.
- Score arithmetic (BCD):
  - dig0 counts 0..9; 9+1 gives dig0 = 0 and carries into dig1.
  - 99+1 wraps to 00.
  - Digits never hold values above 9.
- Boundary rules:
  - hit and miss in the same PLAY cycle: the hit is counted and the miss is processed (both take effect).
  - hit or miss outside PLAY: ignored.
  - btn held through the NEWGAME to PLAY transition has no further effect in PLAY.
  - btn held in NEWBALL while the timer runs: PLAY is entered on the first cycle the timer reads 0.
  - refr_tick outside NEWBALL/OVER only decrements a nonzero timer; this cannot occur in normal flow.
  - Asserting reset mid-game forces all reset values immediately, regardless of state.

## Timing
- Inputs are sampled on the rising clk edge; state and outputs update on that same edge (1-cycle latency).
- Score latency: dig0/dig1 reflect a hit on the edge that samples it; the carry into dig1 happens on the same edge.
- gra_still changes on the same edge as the state register.
- Timer expiry:
  - With timer = 1, a refr_tick sets timer = 0 at that edge.
  - The exit from NEWBALL/OVER occurs at the next edge where the condition holds, i.e. at least 1 cycle after the final tick.
- Total pause is PAUSE_FRAMES refresh ticks plus at most 1 clk.
- No handshake: the pulse inputs must be single-cycle. A pulse held high for N cycles in PLAY counts N hits.

## Test plan
- Reset and start:
  - Assert reset, then release. Expect state = 00, dig = 0/0, ball = 3, gra_still = 1.
  - Then btn = 01 for 1 cycle. Expect state = 01, ball = 2, gra_still = 0.
- BCD carry and wrap:
  - In PLAY, issue 9 hits. Expect dig1/dig0 = 0/9.
  - 1 more hit. Expect 1/0.
  - Total 100 hits. Expect 0/0.
- Miss and pause:
  - In PLAY with ball = 2, issue a miss. Expect state = 10, ball = 1, gra_still = 1.
  - With btn held: 119 ticks keep state = 10; after the 120th tick, state = 01 one cycle later.
- Game over:
  - With ball = 0, issue a miss. Expect state = 11.
  - After 120 ticks, expect state = 00, ball = 3, score retained.
  - Then btn clears the score to 0/0.
- Simultaneous events:
  - hit and miss in the same cycle with score 0/4 and ball = 1. Expect score 0/5, ball = 0, state = 10.
  - A hit in NEWBALL leaves the score unchanged.
- Reset mid-operation:
  - Assert reset in NEWBALL with timer = 60 and score 3/7. Expect immediate state = 00, dig = 0/0, ball = 3, gra_still = 1.
